// File: rtl/prng_pkg.sv
// -----------------------------------------------------------------------------
// prng_pkg
// Shared types and constants for the Galois LFSR word generator.
//   gen_state_t : generator FSM state (FILL = shifting bits in, HOLD = word
//                 presented on the output handshake).
//   TAPS_*      : maximal-length Galois feedback masks for common widths.
// -----------------------------------------------------------------------------
package prng_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } gen_state_t;

    localparam logic [3:0]  TAPS_4  = 4'hC;
    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [31:0] TAPS_32 = 32'h80200003;

    // Width of a counter that must hold 0..n-1; at least one bit so that a
    // single-bit word still has a legal counter vector.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prng_lfsr_core.sv
// -----------------------------------------------------------------------------
// prng_lfsr_core
// Galois LFSR state register with seed load and zero-seed substitution.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   synchronous active-high reset (state <= SEED_DEFAULT)
//   load_i       in   load seed_i this cycle (wins over step_i)
//   seed_i       in   seed value; zero is replaced by SEED_DEFAULT
//   step_i       in   advance the LFSR by one step
//   lfsr_q_o     out  current LFSR state
//   bit_o        out  bit emitted by a step taken this cycle (lfsr_q[0])
//   lfsr_next_o  out  state after a step from the current state
//   seed_sub_o   out  seed_i after zero substitution
// -----------------------------------------------------------------------------
module prng_lfsr_core
    import prng_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = TAPS_16,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = 16'hACE1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] lfsr_q_o,
    output logic             bit_o,
    output logic [WIDTH-1:0] lfsr_next_o,
    output logic [WIDTH-1:0] seed_sub_o
);

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;
    logic [WIDTH-1:0] lfsr_next;
    logic [WIDTH-1:0] seed_sub;
    logic             emit;

    // An all-zero state is a fixed point of the LFSR, so it is never loaded.
    assign seed_sub  = (seed_i == '0) ? SEED_DEFAULT : seed_i;

    // Galois step: shift right, fold the taps in when the outgoing bit is 1.
    assign emit      = lfsr_q[0];
    assign lfsr_next = (lfsr_q >> 1) ^ (emit ? TAPS : '0);

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = seed_sub;
        end else if (step_i) begin
            lfsr_d = lfsr_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= SEED_DEFAULT;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_q_o    = lfsr_q;
    assign bit_o       = emit;
    assign lfsr_next_o = lfsr_next;
    assign seed_sub_o  = seed_sub;

endmodule

// File: rtl/prng_lfsr_gen.sv
// -----------------------------------------------------------------------------
// prng_lfsr_gen
// Pseudo-random word generator: steps a Galois LFSR once per cycle, packs
// OUT_W emitted bits MSB-first into a word, then holds the word on a
// valid/ready handshake until it is consumed.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous active-high reset
//   seed_load  in   reload the LFSR from seed (highest priority after reset)
//   seed       in   seed value (zero is replaced by SEED_DEFAULT)
//   out_ready  in   consumer accepts out_data
//   out_valid  out  out_data holds a complete word
//   out_data   out  generated word
//   busy       out  1 while a word is being filled
//   wrap       out  (PRNG_WRAP_DETECT_EN only) one-cycle pulse when a step
//                   returns the LFSR to the last loaded seed
//
// Build option: define PRNG_WRAP_DETECT_EN to add the wrap output and the
// seed_q tracking register.
// -----------------------------------------------------------------------------
module prng_lfsr_gen
    import prng_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = TAPS_16,
    parameter int               OUT_W        = 8,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = 16'hACE1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             busy
`ifdef PRNG_WRAP_DETECT_EN
    ,
    output logic             wrap
`endif
);

    localparam int CNT_W = cnt_width(OUT_W);

    gen_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             valid_q;
    logic [OUT_W-1:0] data_q;
    logic [OUT_W-1:0] data_shift;

    logic             step;
    logic             emit;
    logic [WIDTH-1:0] core_lfsr;
    logic [WIDTH-1:0] core_next;
    logic [WIDTH-1:0] core_seed;

    // A seed load suppresses the step in the same cycle.
    assign step = (state_q == FILL) && !seed_load;

    prng_lfsr_core #(
        .WIDTH       (WIDTH),
        .TAPS        (TAPS),
        .SEED_DEFAULT(SEED_DEFAULT)
    ) u_core (
        .clock      (clock),
        .reset      (reset),
        .load_i     (seed_load),
        .seed_i     (seed),
        .step_i     (step),
        .lfsr_q_o   (core_lfsr),
        .bit_o      (emit),
        .lfsr_next_o(core_next),
        .seed_sub_o (core_seed)
    );

    // First emitted bit travels up to the MSB; a 1-bit word is just the bit.
    generate
        if (OUT_W == 1) begin : g_pack1
            assign data_shift = emit;
        end else begin : g_packn
            assign data_shift = {data_q[OUT_W-2:0], emit};
        end
    endgenerate

    // Generator FSM. seed_load overrides everything but reset; if it lands on
    // a handshake cycle the word is consumed and the load still applies,
    // which is the same end state either way.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FILL;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (seed_load) begin
            state_q <= FILL;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    data_q <= data_shift;
                    if (cnt_q == CNT_W'(OUT_W - 1)) begin
                        cnt_q   <= '0;
                        state_q <= HOLD;
                        valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (valid_q && out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= FILL;
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign busy      = (state_q == FILL);

`ifdef PRNG_WRAP_DETECT_EN
    logic [WIDTH-1:0] seed_q;
    logic             wrap_q;

    // A step that lands back on the loaded seed closes one full period.
    always_ff @(posedge clock) begin
        if (reset) begin
            seed_q <= SEED_DEFAULT;
            wrap_q <= 1'b0;
        end else if (seed_load) begin
            seed_q <= core_seed;
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= step && (core_next == seed_q);
        end
    end

    assign wrap = wrap_q;

    logic unused_core;
    assign unused_core = ^core_lfsr;
`else
    logic unused_core;
    assign unused_core = ^{core_lfsr, core_next, core_seed};
`endif

endmodule
